// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: handshake bundle between pipeline stages and the pipeline
// hazard/stall controller.
//   Decode side : dec_valid, dec_read_a/b, dec_arg_a/b
//   Read side   : rd_load, rd_dst_reg, br_taken
//   Exe/memory  : exe_mem_en, mem_ready
//   Controls    : pc_hold, dec_hold, rd_hold, rd_bubble, flush
//   Status      : state, stall_cycles, mem_timeout
// slave  = the controller (pipe_ctrl); master = the pipeline / testbench.
interface pipe_ctrl_if;
  logic        dec_valid;
  logic        dec_read_a;
  logic        dec_read_b;
  logic [3:0]  dec_arg_a;
  logic [3:0]  dec_arg_b;
  logic        rd_load;
  logic [3:0]  rd_dst_reg;
  logic        br_taken;
  logic        exe_mem_en;
  logic        mem_ready;
  logic        pc_hold;
  logic        dec_hold;
  logic        rd_hold;
  logic        rd_bubble;
  logic        flush;
  logic [1:0]  state;
  logic [15:0] stall_cycles;
  logic        mem_timeout;

  modport slave (
    input  dec_valid, dec_read_a, dec_read_b, dec_arg_a, dec_arg_b,
           rd_load, rd_dst_reg, br_taken, exe_mem_en, mem_ready,
    output pc_hold, dec_hold, rd_hold, rd_bubble, flush,
           state, stall_cycles, mem_timeout
  );

  modport master (
    output dec_valid, dec_read_a, dec_read_b, dec_arg_a, dec_arg_b,
           rd_load, rd_dst_reg, br_taken, exe_mem_en, mem_ready,
    input  pc_hold, dec_hold, rd_hold, rd_bubble, flush,
           state, stall_cycles, mem_timeout
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard and stall controller.
// Detects load-use hazards, taken-branch flushes and memory waits and drives
// the stage hold/bubble/flush controls (Mealy: combinational from state,
// counter and inputs). Keeps a saturating count of PC-hold cycles and a
// sticky memory-timeout flag.
// Ports:
//   cpu_clk  - clock, all state on rising edge
//   cpu_rst  - synchronous active-high reset; also forces controls to 0
//   bus      - pipe_ctrl_if.slave (stage inputs, controls, status)
module pipe_ctrl #(
  parameter int LOAD_LAT    = 2,
  parameter int FLUSH_DEPTH = 2,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic         cpu_clk,
  input  logic         cpu_rst,
  pipe_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STALL_LOAD = 2'd1,
    WAIT_MEM   = 2'd2,
    FLUSH      = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic        mem_timeout_q, mem_timeout_d;

  logic hazard;
  logic mem_stall;
  logic pc_hold, dec_hold, rd_hold, rd_bubble, flush;

  // Register 0 is deliberately not exempt from the hazard compare.
  assign hazard = bus.dec_valid & bus.rd_load &
                  ((bus.dec_read_a & (bus.dec_arg_a == bus.rd_dst_reg)) |
                   (bus.dec_read_b & (bus.dec_arg_b == bus.rd_dst_reg)));
  assign mem_stall = bus.exe_mem_en & ~bus.mem_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_hold   = 1'b0;
    dec_hold  = 1'b0;
    rd_hold   = 1'b0;
    rd_bubble = 1'b0;
    flush     = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          pc_hold  = 1'b1;
          dec_hold = 1'b1;
          rd_hold  = 1'b1;
          state_d  = WAIT_MEM;
          cnt_d    = 8'd1;
        end else if (bus.br_taken) begin
          flush     = 1'b1;
          rd_bubble = 1'b1;
          if (FLUSH_DEPTH > 1) begin
            state_d = FLUSH;
            cnt_d   = 8'(FLUSH_DEPTH - 1);
          end
        end else if (hazard) begin
          pc_hold   = 1'b1;
          dec_hold  = 1'b1;
          rd_bubble = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = STALL_LOAD;
            cnt_d   = 8'(LOAD_LAT - 1);
          end
        end
      end
      STALL_LOAD: begin
        pc_hold   = 1'b1;
        dec_hold  = 1'b1;
        rd_bubble = 1'b1;
        cnt_d     = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = RUN;
      end
      FLUSH: begin
        flush     = 1'b1;
        rd_bubble = 1'b1;
        cnt_d     = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = RUN;
      end
      WAIT_MEM: begin
        pc_hold  = ~bus.mem_ready;
        dec_hold = ~bus.mem_ready;
        rd_hold  = ~bus.mem_ready;
        if (bus.mem_ready) begin
          state_d = RUN;
        end else if (cnt_q != 8'hFF) begin
          // Counter parks at its maximum so the timeout compare stays valid.
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = RUN;
    endcase

    if (cpu_rst) begin
      pc_hold   = 1'b0;
      dec_hold  = 1'b0;
      rd_hold   = 1'b0;
      rd_bubble = 1'b0;
      flush     = 1'b0;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (pc_hold && (stall_cycles_q != 16'hFFFF))
      stall_cycles_d = stall_cycles_q + 16'd1;
    mem_timeout_d = mem_timeout_q |
                    ((state_q == WAIT_MEM) && (cnt_q == 8'(MEM_TIMEOUT)));
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q        <= RUN;
      cnt_q          <= 8'd0;
      stall_cycles_q <= 16'd0;
      mem_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
      mem_timeout_q  <= mem_timeout_d;
    end
  end

  assign bus.pc_hold      = pc_hold;
  assign bus.dec_hold     = dec_hold;
  assign bus.rd_hold      = rd_hold;
  assign bus.rd_bubble    = rd_bubble;
  assign bus.flush        = flush;
  assign bus.state        = state_q;
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.mem_timeout  = mem_timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scoreboard bench for pipe_ctrl (LOAD_LAT=2,
// FLUSH_DEPTH=2, MEM_TIMEOUT=3). The driver applies one input vector per
// cycle and queues the hand-computed expected outputs; the monitor pops and
// compares on the falling edge of the same cycle.
module tb_pipe_ctrl;
  logic cpu_clk;
  logic cpu_rst;
  pipe_ctrl_if bus ();

  pipe_ctrl #(.LOAD_LAT(2), .FLUSH_DEPTH(2), .MEM_TIMEOUT(3)) dut (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .bus     (bus.slave)
  );

  // {pc_hold, dec_hold, rd_hold, rd_bubble, flush, state[1:0], stall_cycles[15:0], mem_timeout}
  logic [23:0] exp_q[$];
  string       name_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  initial begin
    cpu_clk = 1'b0;
    forever #5 cpu_clk = ~cpu_clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : monitor
    logic [23:0] e;
    logic [23:0] a;
    string       nm;
    forever begin
      @(negedge cpu_clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {bus.pc_hold, bus.dec_hold, bus.rd_hold, bus.rd_bubble, bus.flush,
              bus.state, bus.stall_cycles, bus.mem_timeout};
        n_vec++;
        if (a !== e) begin
          n_err++;
          $display("FAIL %s: got pc/dec/rd/bub/fl=%b%b%b%b%b st=%0d stall=%0d to=%b, want %b%b%b%b%b st=%0d stall=%0d to=%b",
                   nm, a[23], a[22], a[21], a[20], a[19], a[18:17], a[16:1], a[0],
                   e[23], e[22], e[21], e[20], e[19], e[18:17], e[16:1], e[0]);
        end
      end
    end
  end

  task automatic cyc(input string nm, input logic rst,
                     input logic dv, input logic ra, input logic [3:0] aa,
                     input logic rb, input logic [3:0] ab,
                     input logic ld, input logic [3:0] dst,
                     input logic br, input logic me, input logic mr,
                     input logic pc, input logic dh, input logic rh,
                     input logic bub, input logic fl, input logic [1:0] st,
                     input logic [15:0] sc, input logic to);
    @(posedge cpu_clk);
    #1;
    cpu_rst        = rst;
    bus.dec_valid  = dv;
    bus.dec_read_a = ra;
    bus.dec_arg_a  = aa;
    bus.dec_read_b = rb;
    bus.dec_arg_b  = ab;
    bus.rd_load    = ld;
    bus.rd_dst_reg = dst;
    bus.br_taken   = br;
    bus.exe_mem_en = me;
    bus.mem_ready  = mr;
    exp_q.push_back({pc, dh, rh, bub, fl, st, sc, to});
    name_q.push_back(nm);
  endtask

  initial begin : driver
    cpu_rst        = 1'b1;
    bus.dec_valid  = 1'b0;
    bus.dec_read_a = 1'b0;
    bus.dec_arg_a  = 4'd0;
    bus.dec_read_b = 1'b0;
    bus.dec_arg_b  = 4'd0;
    bus.rd_load    = 1'b0;
    bus.rd_dst_reg = 4'd0;
    bus.br_taken   = 1'b0;
    bus.exe_mem_en = 1'b0;
    bus.mem_ready  = 1'b0;
    @(posedge cpu_clk);

    //  name            rst dv ra aa rb ab ld dst br me mr   pc dh rh bb fl st stall to
    cyc("rst_hold",      1, 1, 0, 0, 1, 5, 1, 5,  1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    // load-use on operand b, LOAD_LAT=2
    cyc("lu_c1",         0, 1, 0, 0, 1, 5, 1, 5,  0, 0, 0,   1, 1, 0, 1, 0, 0, 0, 0);
    cyc("lu_c2",         0, 1, 0, 0, 1, 5, 1, 5,  0, 0, 0,   1, 1, 0, 1, 0, 1, 1, 0);
    cyc("lu_c3",         0, 1, 0, 0, 1, 5, 0, 5,  0, 0, 0,   0, 0, 0, 0, 0, 0, 2, 0);
    // same registers, operand b not read: no hazard
    cyc("nohaz_a",       0, 1, 0, 0, 0, 5, 1, 5,  0, 0, 0,   0, 0, 0, 0, 0, 0, 2, 0);
    cyc("nohaz_b",       0, 1, 0, 0, 0, 5, 1, 5,  0, 0, 0,   0, 0, 0, 0, 0, 0, 2, 0);
    // register 0 on operand a is a hazard; branch during STALL_LOAD ignored
    cyc("r0_haz",        0, 1, 1, 0, 0, 0, 1, 0,  0, 0, 0,   1, 1, 0, 1, 0, 0, 2, 0);
    cyc("r0_stall_br",   0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0,   1, 1, 0, 1, 0, 1, 3, 0);
    cyc("r0_done",       0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0, 4, 0);
    cyc("no_dec_valid",  0, 0, 1, 3, 0, 0, 1, 3,  0, 0, 0,   0, 0, 0, 0, 0, 0, 4, 0);
    // taken branch, second pulse inside FLUSH ignored
    cyc("br_c1",         0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0,   0, 0, 0, 1, 1, 0, 4, 0);
    cyc("br_ignored",    0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0,   0, 0, 0, 1, 1, 3, 4, 0);
    cyc("br_done",       0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0, 4, 0);
    // memory wait 4 cycles; counter reaches MEM_TIMEOUT=3 on the 4th
    cyc("mem_c1",        0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0,   1, 1, 1, 0, 0, 0, 4, 0);
    cyc("mem_c2",        0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0,   1, 1, 1, 0, 0, 2, 5, 0);
    cyc("mem_c3",        0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0,   1, 1, 1, 0, 0, 2, 6, 0);
    cyc("mem_c4",        0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0,   1, 1, 1, 0, 0, 2, 7, 0);
    cyc("mem_ready",     0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1,   0, 0, 0, 0, 0, 2, 8, 1);
    cyc("mem_done",      0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0, 8, 1);
    // priority: mem stall beats branch and hazard; branch honored only in RUN
    cyc("prio",          0, 1, 0, 0, 1, 5, 1, 5,  1, 1, 0,   1, 1, 1, 0, 0, 0, 8, 1);
    cyc("prio_ready",    0, 1, 0, 0, 1, 5, 1, 5,  1, 1, 1,   0, 0, 0, 0, 0, 2, 9, 1);
    cyc("prio_br_run",   0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0,   0, 0, 0, 1, 1, 0, 9, 1);
    cyc("prio_flush",    0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 1, 1, 3, 9, 1);
    cyc("prio_done",     0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0, 9, 1);
    // reset mid-flush clears status, next cycle behaves as RUN
    cyc("fl_pre_rst",    0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0,   0, 0, 0, 1, 1, 0, 9, 1);
    cyc("rst_mid_flush", 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0,   0, 0, 0, 0, 0, 3, 9, 1);
    cyc("rel_br",        0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0,   0, 0, 0, 1, 1, 0, 0, 0);
    cyc("rel_flush",     0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 1, 1, 3, 0, 0);
    cyc("rel_done",      0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    // reset mid-stall
    cyc("haz_pre_rst",   0, 1, 0, 0, 1, 5, 1, 5,  0, 0, 0,   1, 1, 0, 1, 0, 0, 0, 0);
    cyc("rst_mid_stall", 1, 1, 0, 0, 1, 5, 1, 5,  0, 0, 0,   0, 0, 0, 0, 0, 1, 1, 0);
    cyc("rel_idle",      0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);

    @(posedge cpu_clk);
    @(posedge cpu_clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter LOAD_LAT, default 2, total stall cycles inserted for a load-use hazard (legal 1..7).
REQ-002 Parameter FLUSH_DEPTH, default 2, cycles flush is asserted after a taken redirect (legal 1..7).
REQ-003 Parameter MEM_TIMEOUT, default 255, WAIT_MEM cycle count that sets mem_timeout (legal 1..255).
REQ-004 Ports:
- cpu_clk  in  1  sole clock; all state on rising edge.
- cpu_rst  in  1  synchronous, active-high reset.
- dec_valid  in  1  decode stage holds a valid instruction.
- dec_read_a / dec_read_b  in  1 each  decode instruction reads operand a / b.
- dec_arg_a / dec_arg_b  in  4 each  operand a / b register index.
- rd_load  in  1  read-stage instruction is a load (mem_en & !mem_write) writing a register.
- rd_dst_reg  in  4  destination register of the read-stage load.
- br_taken  in  1  read stage issues pc_set or pc_add this cycle.
- exe_mem_en  in  1  exe stage performs a memory access this cycle.
- mem_ready  in  1  memory completes the access this cycle.
- pc_hold  out  1  fetch holds PC.
- dec_hold  out  1  decode register holds.
- rd_hold  out  1  read and exe stage registers hold.
- rd_bubble  out  1  read stage passes a NOP (all enables 0) to exe.
- flush  out  1  invalidate fetch/decode contents.
- state  out  2  RUN=0, STALL_LOAD=1, WAIT_MEM=2, FLUSH=3.
- stall_cycles  out  16  saturating count of cycles with pc_hold=1.
- mem_timeout  out  1  sticky memory-timeout flag.

Function
REQ-005 Control outputs are combinational from state, counter, and inputs (Mealy); state, counters, and flags are registered.
REQ-006 hazard = dec_valid & rd_load & ((dec_read_a & dec_arg_a==rd_dst_reg) | (dec_read_b & dec_arg_b==rd_dst_reg)); register 0 is not exempt.
REQ-007 RUN priority: mem stall (exe_mem_en & !mem_ready) > br_taken > hazard > advance.
REQ-008 RUN, mem stall: pc_hold=dec_hold=rd_hold=1, rd_bubble=0; next state WAIT_MEM, wait counter=1.
REQ-009 RUN, br_taken: flush=1, rd_bubble=1, holds=0; next FLUSH with cnt=FLUSH_DEPTH-1, or RUN if FLUSH_DEPTH=1.
REQ-010 RUN, hazard: pc_hold=dec_hold=1, rd_bubble=1, rd_hold=0; next STALL_LOAD with cnt=LOAD_LAT-1, or RUN if LOAD_LAT=1.
REQ-011 RUN otherwise: all control outputs 0.
REQ-012 STALL_LOAD: pc_hold=dec_hold=rd_bubble=1; cnt decrements; RUN when cnt reaches 0 after decrement. br_taken and hazard are ignored.
REQ-013 FLUSH: flush=rd_bubble=1; cnt decrements; RUN when it reaches 0. br_taken is ignored.
REQ-014 WAIT_MEM: pc_hold=dec_hold=rd_hold=!mem_ready; counter increments while !mem_ready.
REQ-015 WAIT_MEM exits: RUN in the mem_ready=1 cycle; br_taken and hazard are not evaluated until the next RUN cycle.
REQ-016 mem_timeout sets when the WAIT_MEM counter reaches MEM_TIMEOUT and stays set until reset; the FSM keeps waiting.
REQ-017 stall_cycles increments on every cycle pc_hold=1 and saturates at 16'hFFFF without wrapping.

Reset
REQ-018 While cpu_rst=1, all control outputs are forced to 0.
REQ-019 On a clock edge with cpu_rst=1: state=RUN, all counters=0, stall_cycles=0, mem_timeout=0.
REQ-020 Reset asserted in any state, mid-stall or mid-flush, abandons that operation; the cycle after reset release behaves as RUN.

Verification
REQ-021 Load-use, defaults: rd_load=1, rd_dst_reg=5, dec_valid=1, dec_read_b=1, dec_arg_b=5 -> pc_hold, dec_hold, rd_bubble high 2 cycles; state 0,1,0; stall_cycles=2.
REQ-022 No hazard: same stimulus with dec_read_b=0 -> all control outputs 0, state stays 0.
REQ-023 Taken branch: br_taken=1 for one cycle -> flush=rd_bubble=1 for 2 cycles; a second br_taken pulse in the FLUSH cycle is ignored.
REQ-024 Memory wait: exe_mem_en=1, mem_ready=0 for 4 cycles then 1 -> all holds high exactly 4 cycles, low in the ready cycle; state returns to 0; stall_cycles=4.
REQ-025 Priority: mem stall, br_taken, and hazard all in one RUN cycle -> WAIT_MEM entered, flush=0; br_taken honored only when re-presented in RUN.
REQ-026 Timeout/reset: MEM_TIMEOUT=3, mem_ready=0 for 5 cycles -> mem_timeout=1 stays set; cpu_rst pulse -> mem_timeout=0, state=0, stall_cycles=0.
